rr_arbiter8: RTL

//  8-way round-robin arbiter for a shared resource whose select lines are driven by the

---
 rtl/rr_arbiter8_if.sv | 21 ++
 rtl/rr_arbiter8.sv | 83 ++++++++
 2 files changed

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between the requesters and the arbiter.
//   en        : arbitration enable (gates new grants only)
//   req[7:0]  : one request bit per requester
//   rel       : release strobe from the current owner
//   gnt[7:0]  : one-hot grant, zero when idle
//   gnt_idx   : binary index of the owner (drives the 3x8 select decoder)
//   gnt_valid : grant active
//   timeout   : one-cycle pulse when a grant is forcibly released
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (output en, req, rel, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave  (input en, req, rel, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way round-robin arbiter with hold timeout.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : rr_arbiter8_if.slave (en/req/rel in, gnt/gnt_idx/gnt_valid/timeout out)
// A grant is held until the owner pulses rel, drops its request, or has held
// it for MAX_HOLD cycles. After every release the arbiter spends one cycle in
// IDLE, and the released owner becomes lowest priority for the next round.
// All outputs come straight from registers.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter8_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]        state;
  logic [2:0]        ptr;
  logic [2:0]        idx_q;
  logic [7:0]        gnt_q;
  logic              tmo_q;
  logic [HOLD_W-1:0] hold;
  logic [2:0]        win;
  logic              rel_norm;
  logic              rel_force;

  // Rotating priority scan: offset 0 from ptr is highest priority. Walking
  // offsets from 7 down to 0 lets the closest set bit overwrite the others.
  always_comb begin
    win = ptr;
    for (int k = 7; k >= 0; k--) begin
      if (bus.req[ptr + 3'(k)]) win = ptr + 3'(k);
    end
  end

  // rel beats request drop beats timeout; only the last one flags timeout.
  assign rel_norm  = bus.rel || !bus.req[idx_q];
  assign rel_force = (hold == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      idx_q <= '0;
      gnt_q <= '0;
      tmo_q <= 1'b0;
      hold  <= '0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.en && |bus.req) begin
            state <= S_GRANT;
            idx_q <= win;
            gnt_q <= 8'b1 << win;
            hold  <= '0;
          end
        end
        default: begin
          if (rel_norm || rel_force) begin
            state <= S_IDLE;
            gnt_q <= '0;
            ptr   <= idx_q + 3'd1;
            tmo_q <= !rel_norm;
          end else begin
            hold <= hold + HOLD_W'(1);
          end
        end
      endcase
    end
  end

  // gnt_idx keeps the last owner while idle; gnt/gnt_valid mark it stale.
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state == S_GRANT);
  assign bus.timeout   = tmo_q;

endmodule
